// File: rtl/iq_accumulator_pkg.sv
// Shared definitions for the IQ gate accumulator: FSM state encoding,
// default widths and gate length, and the sample-counter width.
package iq_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    localparam int DEF_ADC_W    = 14;
    localparam int DEF_LO_W     = 8;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_GATE_LEN = 64;
    localparam int CNT_W        = 16;

endpackage

// File: rtl/iq_accumulator_mac.sv
// One accumulator channel: signed ADC x LO product, sign-extended add, overflow
// detection, and wrap or clamp (clamp when IQ_SATURATE_EN is defined).
module iq_mac
    import iq_accumulator_pkg::*;
#(
    parameter int ADC_W = DEF_ADC_W,
    parameter int LO_W  = DEF_LO_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [ADC_W-1:0] i_adc,
    input  logic signed [LO_W-1:0]  i_lo,
    output logic signed [ACC_W-1:0] o_acc_next,
    output logic                    o_ovf_next
);

    localparam int PROD_W = ADC_W + LO_W;

    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_ovf;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W-1:0]  w_acc_add;
    logic                     w_ovf;

    assign w_prod = i_adc * i_lo;
    // A clear on the same edge as an accepted sample starts the new gate from that sample.
    assign w_base = i_clr ? '0 : r_acc;
    assign w_sum  = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_prod);
    assign w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef IQ_SATURATE_EN
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
        if (s[ACC_W] ^ s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    assign w_acc_add = sat_acc(w_sum);
`else
    assign w_acc_add = w_sum[ACC_W-1:0];
`endif

    assign o_acc_next = i_en ? w_acc_add : w_base;
    assign o_ovf_next = (i_clr ? 1'b0 : r_ovf) | (i_en & w_ovf);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= o_acc_next;
            r_ovf <= o_ovf_next;
        end
    end

endmodule

// File: rtl/iq_accumulator.sv
// Gated I/Q accumulator: sums sin*adc and cos*adc over GATE_LEN accepted samples
// and presents the result with a valid/ready handshake. Option: IQ_SATURATE_EN.
module iq_accumulator
    import iq_accumulator_pkg::*;
#(
    parameter int ADC_W    = DEF_ADC_W,
    parameter int LO_W     = DEF_LO_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int GATE_LEN = DEF_GATE_LEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    in_valid,
    input  logic signed [ADC_W-1:0] adc,
    input  logic signed [LO_W-1:0]  sin,
    input  logic signed [LO_W-1:0]  cos,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] i_out,
    output logic signed [ACC_W-1:0] q_out,
    output logic                    ovf,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GATE_LEN - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_base;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_i_out;
    logic signed [ACC_W-1:0] r_q_out;
    logic                    r_ovf;
    logic                    w_rearm;
    logic                    w_handshake;
    logic                    w_clear;
    logic                    w_accept;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_i_next;
    logic signed [ACC_W-1:0] w_q_next;
    logic                    w_i_ovf;
    logic                    w_q_ovf;

    assign w_rearm     = start | continuous;
    assign w_handshake = (r_state == ST_DUMP) && out_ready;
    assign w_cnt_base  = w_clear ? '0 : r_cnt;
    assign w_last      = w_accept && (w_cnt_base == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_rearm) w_state_next = ST_ACCUM;
            ST_ACCUM: if (w_last) w_state_next = ST_DUMP;
            ST_DUMP: begin
                if (w_handshake) begin
                    if (w_last)
                        w_state_next = ST_DUMP;
                    else if (w_rearm)
                        w_state_next = ST_ACCUM;
                    else
                        w_state_next = ST_IDLE;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // A re-arming handshake accepts that cycle's sample so continuous gates lose nothing.
    always_comb begin
        w_clear  = 1'b0;
        w_accept = 1'b0;
        busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  w_clear = w_rearm;
            ST_ACCUM: w_accept = in_valid;
            ST_DUMP: begin
                w_clear  = w_handshake & w_rearm;
                w_accept = w_handshake & w_rearm & in_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_base + CNT_W'(1);
        end else begin
            r_cnt <= w_cnt_base;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_i_out     <= '0;
            r_q_out     <= '0;
            r_ovf       <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_i_out     <= w_i_next;
            r_q_out     <= w_q_next;
            r_ovf       <= w_i_ovf | w_q_ovf;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign i_out     = r_i_out;
    assign q_out     = r_q_out;
    assign ovf       = r_ovf;

    iq_mac #(
        .ADC_W (ADC_W),
        .LO_W  (LO_W),
        .ACC_W (ACC_W)
    ) u_mac_i (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clr      (w_clear),
        .i_en       (w_accept),
        .i_adc      (adc),
        .i_lo       (sin),
        .o_acc_next (w_i_next),
        .o_ovf_next (w_i_ovf)
    );

    iq_mac #(
        .ADC_W (ADC_W),
        .LO_W  (LO_W),
        .ACC_W (ACC_W)
    ) u_mac_q (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clr      (w_clear),
        .i_en       (w_accept),
        .i_adc      (adc),
        .i_lo       (cos),
        .o_acc_next (w_q_next),
        .o_ovf_next (w_q_ovf)
    );

endmodule

// File: tb/tb_iq_accumulator.sv
// Bench for iq_accumulator: a wide-accumulator and a narrow (22-bit) instance
// share stimulus; results are compared with an arithmetic gate model.
module tb_iq_accumulator;

    localparam int GL = 4;

`ifdef IQ_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, continuous, in_valid, out_ready;
    logic signed [13:0] adc;
    logic signed [7:0]  sin_v, cos_v;

    logic               ov32, of32, busy32;
    logic signed [31:0] i32, q32;
    logic               ov22, of22, busy22;
    logic signed [21:0] i22, q22;

    int checks = 0;
    int errors = 0;
    int s_adc[GL], s_sin[GL], s_cos[GL];

    always #5 clk = ~clk;

    iq_accumulator #(.ADC_W(14), .LO_W(8), .ACC_W(32), .GATE_LEN(GL)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .in_valid(in_valid), .adc(adc), .sin(sin_v), .cos(cos_v),
        .out_ready(out_ready), .out_valid(ov32), .i_out(i32), .q_out(q32),
        .ovf(of32), .busy(busy32)
    );

    iq_accumulator #(.ADC_W(14), .LO_W(8), .ACC_W(22), .GATE_LEN(GL)) dut22 (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .in_valid(in_valid), .adc(adc), .sin(sin_v), .cos(cos_v),
        .out_ready(out_ready), .out_valid(ov22), .i_out(i22), .q_out(q22),
        .ovf(of22), .busy(busy22)
    );

    // Reference: running sum of the gate's products, wrapped or clamped at accw bits.
    function automatic void model(input int ch, input int accw, output longint val, output bit ov);
        longint mx  = (longint'(1) <<< (accw - 1)) - 1;
        longint mn  = -(longint'(1) <<< (accw - 1));
        longint m   = longint'(1) <<< accw;
        longint acc = 0;
        longint s, p;
        ov = 1'b0;
        for (int i = 0; i < GL; i++) begin
            p = longint'(s_adc[i]) * longint'((ch == 0) ? s_sin[i] : s_cos[i]);
            s = acc + p;
            if (s > mx || s < mn) begin
                ov = 1'b1;
                if (SAT) begin
                    acc = (s > mx) ? mx : mn;
                end else begin
                    acc = s & (m - 1);
                    if (acc > mx) acc = acc - m;
                end
            end else begin
                acc = s;
            end
        end
        val = acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int a, input int sv, input int cv);
        for (int i = 0; i < GL; i++) begin
            s_adc[i] = a; s_sin[i] = sv; s_cos[i] = cv;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < GL; i++) begin
            s_adc[i] = int'($urandom_range(0, 16383)) - 8192;
            s_sin[i] = int'($urandom_range(0, 255)) - 128;
            s_cos[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic junk_inputs();
        adc   = 14'($urandom);
        sin_v = 8'($urandom);
        cos_v = 8'($urandom);
    endtask

    // Drives one gate from IDLE; reports out_valid before and after the last sample edge.
    task automatic run_gate(input int max_gap, output bit pre_ov, output bit post_ov);
        in_valid = 1'b1; junk_inputs(); step();
        start = 1'b1; step(); start = 1'b0;
        pre_ov = 1'b0;
        for (int i = 0; i < GL; i++) begin
            int gap = int'($urandom_range(0, max_gap));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; junk_inputs(); start = 1'($urandom_range(0, 1)); step();
            end
            start = 1'b0;
            in_valid = 1'b1;
            adc = 14'(s_adc[i]); sin_v = 8'(s_sin[i]); cos_v = 8'(s_cos[i]);
            if (i == GL - 1) pre_ov = ov32;
            step();
        end
        post_ov = ov32;
        in_valid = 1'b0;
    endtask

    task automatic finish_gate();
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        checks++;
        if ({ov32, of32, busy32, i32, q32} !== '0) begin
            errors++; $display("FAIL reset32 got ov=%0b ovf=%0b busy=%0b i=%0d q=%0d want all 0", ov32, of32, busy32, i32, q32);
        end
        checks++;
        if ({ov22, of22, busy22, i22, q22} !== '0) begin
            errors++; $display("FAIL reset22 got ov=%0b ovf=%0b busy=%0b i=%0d q=%0d want all 0", ov22, of22, busy22, i22, q22);
        end
        reset = 1'b0;
        in_valid = 1'b1; step(); step(); in_valid = 1'b0;
        checks++;
        if (busy32 !== 1'b0 || ov32 !== 1'b0) begin
            errors++; $display("FAIL idle_ignore got busy=%0b ov=%0b want 0 0", busy32, ov32);
        end
    endtask

    task automatic test_basic();
        bit pre, post;
        fill_const(200, 4, 3);
        run_gate(0, pre, post);
        checks++;
        if (pre !== 1'b0 || post !== 1'b1) begin
            errors++; $display("FAIL basic_latency got pre=%0b post=%0b want 0 1", pre, post);
        end
        checks++;
        if (i32 !== 32'sd3200 || q32 !== 32'sd2400 || of32 !== 1'b0 || busy32 !== 1'b1) begin
            errors++; $display("FAIL basic_sums got i=%0d q=%0d ovf=%0b busy=%0b want 3200 2400 0 1", i32, q32, of32, busy32);
        end
        finish_gate();
        checks++;
        if (ov32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++; $display("FAIL basic_handshake got ov=%0b busy=%0b want 0 0", ov32, busy32);
        end
    endtask

    task automatic test_extremes();
        bit pre, post, mov;
        longint mq;
        longint exp_i22;
        fill_const(-8192, -128, 127);
        run_gate(2, pre, post);
        checks++;
        if (post !== 1'b1 || i32 !== 32'sd4194304 || q32 !== -32'sd4161536 || of32 !== 1'b0) begin
            errors++; $display("FAIL extreme32 got ov=%0b i=%0d q=%0d ovf=%0b want 1 4194304 -4161536 0", post, i32, q32, of32);
        end
        exp_i22 = SAT ? 64'sd2097151 : 64'sd0;
        model(1, 22, mq, mov);
        checks++;
        if (ov22 !== 1'b1 || longint'(i22) !== exp_i22 || of22 !== 1'b1) begin
            errors++; $display("FAIL extreme22_i got ov=%0b i=%0d ovf=%0b want 1 %0d 1", ov22, i22, of22, exp_i22);
        end
        checks++;
        if (longint'(q22) !== mq || mov !== 1'b1) begin
            errors++; $display("FAIL extreme22_q got q=%0d want %0d", q22, mq);
        end
        finish_gate();
    endtask

    task automatic test_random();
        bit pre, post, oi, oq, oi22, oq22;
        longint ei, eq, ei22, eq22;
        for (int n = 0; n < 8; n++) begin
            fill_random();
            run_gate(3, pre, post);
            model(0, 32, ei, oi);     model(1, 32, eq, oq);
            model(0, 22, ei22, oi22); model(1, 22, eq22, oq22);
            checks++;
            if (post !== 1'b1 || longint'(i32) !== ei || longint'(q32) !== eq || of32 !== (oi | oq)) begin
                errors++; $display("FAIL random32[%0d] got ov=%0b i=%0d q=%0d ovf=%0b want 1 %0d %0d %0b", n, post, i32, q32, of32, ei, eq, oi | oq);
            end
            checks++;
            if (longint'(i22) !== ei22 || longint'(q22) !== eq22 || of22 !== (oi22 | oq22)) begin
                errors++; $display("FAIL random22[%0d] got i=%0d q=%0d ovf=%0b want %0d %0d %0b", n, i22, q22, of22, ei22, eq22, oi22 | oq22);
            end
            finish_gate();
        end
    endtask

    task automatic test_backpressure();
        bit pre, post, oi, oq;
        longint ei, eq;
        logic signed [31:0] hi, hq;
        logic hf;
        fill_random();
        run_gate(1, pre, post);
        hi = i32; hq = q32; hf = of32;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; junk_inputs(); start = 1'($urandom_range(0, 1)); step();
            checks++;
            if (ov32 !== 1'b1 || busy32 !== 1'b1 || i32 !== hi || q32 !== hq || of32 !== hf) begin
                errors++; $display("FAIL hold[%0d] got ov=%0b busy=%0b i=%0d q=%0d want 1 1 %0d %0d", c, ov32, busy32, i32, q32, hi, hq);
            end
        end
        start = 1'b0; in_valid = 1'b0;
        finish_gate();
        fill_random();
        run_gate(2, pre, post);
        model(0, 32, ei, oi); model(1, 32, eq, oq);
        checks++;
        if (post !== 1'b1 || longint'(i32) !== ei || longint'(q32) !== eq) begin
            errors++; $display("FAIL after_hold got ov=%0b i=%0d q=%0d want 1 %0d %0d", post, i32, q32, ei, eq);
        end
        finish_gate();
    endtask

    task automatic test_back_to_back();
        bit oi, oq;
        longint ei, eq;
        int last_t = -1;
        int pulses = 0;
        fill_random();
        for (int i = 1; i < GL; i++) begin
            s_adc[i] = s_adc[0]; s_sin[i] = s_sin[0]; s_cos[i] = s_cos[0];
        end
        model(0, 32, ei, oi); model(1, 32, eq, oq);
        adc = 14'(s_adc[0]); sin_v = 8'(s_sin[0]); cos_v = 8'(s_cos[0]);
        continuous = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int t = 0; t < 40 && pulses < 4; t++) begin
            step();
            if (ov32 === 1'b1) begin
                checks++;
                if (longint'(i32) !== ei || longint'(q32) !== eq) begin
                    errors++; $display("FAIL cont_sum[%0d] got i=%0d q=%0d want %0d %0d", pulses, i32, q32, ei, eq);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (t - last_t !== GL) begin
                        errors++; $display("FAIL cont_period[%0d] got %0d want %0d", pulses, t - last_t, GL);
                    end
                end
                last_t = t;
                pulses++;
            end
        end
        checks++;
        if (pulses < 4) begin
            errors++; $display("FAIL cont_count got %0d gates want 4", pulses);
        end
        continuous = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        reset = 1'b1; step(); reset = 1'b0; step();
    endtask

    task automatic test_reset_midgate();
        bit pre, post, oi, oq;
        longint ei, eq;
        int seen = 0;
        fill_random();
        run_gate(0, pre, post);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({ov32, of32, busy32, i32, q32} !== '0) begin
            errors++; $display("FAIL reset_dump got ov=%0b busy=%0b i=%0d q=%0d want all 0", ov32, busy32, i32, q32);
        end
        step(); reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; adc = 14'(s_adc[i]); sin_v = 8'(s_sin[i]); cos_v = 8'(s_cos[i]); step();
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({ov32, busy32, i32, q32, ov22, busy22} !== '0) begin
            errors++; $display("FAIL reset_gate got ov=%0b busy=%0b i=%0d q=%0d want all 0", ov32, busy32, i32, q32);
        end
        step(); reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; junk_inputs(); step();
            if (ov32 !== 1'b0) seen++;
        end
        in_valid = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_no_valid got %0d valid cycles want 0", seen);
        end
        fill_random();
        run_gate(1, pre, post);
        model(0, 32, ei, oi); model(1, 32, eq, oq);
        checks++;
        if (post !== 1'b1 || longint'(i32) !== ei || longint'(q32) !== eq) begin
            errors++; $display("FAIL reset_regate got ov=%0b i=%0d q=%0d want 1 %0d %0d", post, i32, q32, ei, eq);
        end
        finish_gate();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        adc = '0; sin_v = '0; cos_v = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midgate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

endmodule

// File: doc/iq_accumulator.md
IQ_ACCUMULATOR -- requirements
Module: iq_accumulator

Interface
REQ-001 Parameter ADC_W, default 14: signed ADC sample width.
REQ-002 Parameter LO_W, default 8: signed sine/cosine width from the quadrature table.
REQ-003 Parameter ACC_W, default 32: signed accumulator and result width; legal range ADC_W+LO_W .. 48.
REQ-004 Parameter GATE_LEN, default 64: accepted samples per gate; legal range 1 .. 65535.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle arm request for a new gate.
REQ-008 continuous  in  1  when high, a new gate re-arms automatically after each dump.
REQ-009 in_valid  in  1  adc/sin/cos valid this cycle.
REQ-010 adc  in  ADC_W  signed ADC sample.
REQ-011 sin  in  LO_W  signed in-phase LO value.
REQ-012 cos  in  LO_W  signed quadrature LO value.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_valid  out  1  i_out/q_out/ovf hold a finished gate.
REQ-015 i_out  out  ACC_W  signed sum of sin*adc over the gate.
REQ-016 q_out  out  ACC_W  signed sum of cos*adc over the gate.
REQ-017 ovf  out  1  an accumulator overflowed during the reported gate.
REQ-018 busy  out  1  high in ACCUM or DUMP.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM and DUMP.
REQ-020 IDLE->ACCUM on start, or on continuous=1; accumulators, sample counter and the internal ovf flag are cleared on that edge.
REQ-021 In ACCUM, each cycle with in_valid=1 SHALL add the full-precision signed products sin*adc and cos*adc, sign-extended to ACC_W, to the I and Q accumulators and increment the counter.
REQ-022 On the edge accepting the GATE_LEN-th sample, the final sums SHALL load i_out/q_out, ovf SHALL load, out_valid SHALL rise, and the state SHALL go to DUMP; latency is 1 cycle from last sample to out_valid.
REQ-023 In DUMP, i_out/q_out/ovf SHALL stay stable while out_valid=1 and out_ready=0; in_valid samples are discarded.
REQ-024 On out_valid&&out_ready: out_valid falls; the next state is ACCUM with cleared accumulators if continuous=1 or start=1 that cycle, else IDLE.
REQ-025 start in ACCUM or DUMP (outside REQ-024) SHALL be ignored; in_valid in IDLE SHALL be ignored.
REQ-026 Overflow: if an accumulation's true sum exceeds the ACC_W signed range, the internal ovf flag SHALL set and stay set until the gate is cleared.
REQ-027 GATE_LEN=1 SHALL dump after the first accepted sample.

Reset
REQ-028 While reset=1: state IDLE, out_valid=0, i_out=0, q_out=0, ovf=0, busy=0, accumulators and counter 0, regardless of clk.
REQ-029 Reset asserted mid-gate or mid-DUMP SHALL discard the partial or pending result with no output handshake.

Configuration
REQ-030 With IQ_SATURATE_EN defined, an overflowing accumulation SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and further additions start from the clamped value.
REQ-031 Without IQ_SATURATE_EN, accumulation SHALL wrap modulo 2^ACC_W; ovf is reported in both builds.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the default width/gate constants.
REQ-033 One sub-module, iq_mac (one channel: multiply, sign-extend, accumulate, overflow/saturate), SHALL be instantiated twice, for I and Q.

Verification
REQ-034 GATE_LEN=4, sin=4, cos=3, adc=200 for 4 valid cycles after start -> out_valid 1 cycle after 4th sample, i_out=3200, q_out=2400, ovf=0.
REQ-035 GATE_LEN=4, sin=-128, cos=127, adc=-8192 -> i_out=4194304, q_out=-4161536.
REQ-036 ACC_W=22, GATE_LEN=4, sin=-128, adc=-8192 -> with IQ_SATURATE_EN i_out=2097151, without i_out=0; ovf=1 in both.
REQ-037 out_ready low 5 cycles with in_valid high -> outputs stable, busy=1, samples dropped; next gate sums exclude dropped samples.
REQ-038 continuous=1, out_ready=1, constant input -> back-to-back gates with identical results and no sample lost on the handshake edge.
REQ-039 reset pulse after 2 of 4 samples -> all outputs 0 within the reset cycle; no out_valid until a new start plus 4 samples.
